// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128/AES-256 encryption core, one round per clock.
// Round keys are produced on the fly from a rolling window of key words.
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = xt(t);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31;
    logic [7:0] x62, x63, x126, x127, inv;

    // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
    always_comb begin
        x2   = gm(a_i, a_i);
        x3   = gm(x2, a_i);
        x6   = gm(x3, x3);
        x7   = gm(x6, a_i);
        x14  = gm(x7, x7);
        x15  = gm(x14, a_i);
        x30  = gm(x15, x15);
        x31  = gm(x30, a_i);
        x62  = gm(x31, x31);
        x63  = gm(x62, a_i);
        x126 = gm(x63, x63);
        x127 = gm(x126, a_i);
        inv  = gm(x127, x127);
        s_o  = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_encrypt_iter #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        plain_text,
    input  logic [KEY_BITS-1:0] key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        cipher,
    output logic                busy
);
    localparam int NR = (KEY_BITS == 256) ? 14 : 10;

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_encrypt_iter: KEY_BITS must be 128 or 256");
    end

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

    fsm_e                fsm_q, fsm_d;
    logic [3:0]          round_q, round_d;
    logic [127:0]        blk_q, blk_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [7:0]          rcon_q, rcon_d;

    logic [127:0]        sb, sr, mc, rk, rnd_out;
    logic [127:0]        ka, knew;
    logic [KEY_BITS-1:0] key_nxt;
    logic [31:0]         w_last, kw_in, kw_sub, kt;
    logic                rcon_use, last;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_sb
        aes_sbox u_sbox (
            .a_i (blk_q[127-8*i -: 8]),
            .s_o (sb[127-8*i -: 8])
        );
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
        end
        assign mc[127-32*c -: 32] = mixcol(sr[127-32*c -: 32]);
    end

    // AES-256 alternates RotWord+Rcon (odd rounds) with plain SubWord (even rounds).
    assign rcon_use = (KEY_BITS == 128) || round_q[0];
    assign ka       = key_q[KEY_BITS-1 -: 128];
    assign w_last   = key_q[31:0];
    assign kw_in    = rcon_use ? {w_last[23:0], w_last[31:24]} : w_last;

    for (genvar k = 0; k < 4; k++) begin : g_ksb
        aes_sbox u_sbox (
            .a_i (kw_in[31-8*k -: 8]),
            .s_o (kw_sub[31-8*k -: 8])
        );
    end

    assign kt            = kw_sub ^ (rcon_use ? {rcon_q, 24'h0} : 32'h0);
    assign knew[127:96]  = ka[127:96] ^ kt;
    assign knew[95:64]   = ka[95:64]  ^ knew[127:96];
    assign knew[63:32]   = ka[63:32]  ^ knew[95:64];
    assign knew[31:0]    = ka[31:0]   ^ knew[63:32];

    // AES-256 uses the newer half of its window now and expands ahead by four words.
    if (KEY_BITS == 256) begin : g_k256
        assign key_nxt = {key_q[127:0], knew};
        assign rk      = key_q[127:0];
    end else begin : g_k128
        assign key_nxt = knew;
        assign rk      = knew;
    end

    assign last    = (round_q == 4'(NR));
    assign rnd_out = (last ? sr : mc) ^ rk;

    always_comb begin
        fsm_d     = fsm_q;
        round_d   = round_q;
        blk_d     = blk_q;
        key_d     = key_q;
        rcon_d    = rcon_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    blk_d   = plain_text ^ key[KEY_BITS-1 -: 128];
                    key_d   = key;
                    round_d = 4'd1;
                    rcon_d  = 8'h01;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                blk_d   = rnd_out;
                key_d   = key_nxt;
                round_d = round_q + 4'd1;
                if (rcon_use) rcon_d = xt(rcon_q);
                if (last) fsm_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d   = IDLE;
                    round_d = 4'd0;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            round_q <= 4'd0;
            blk_q   <= 128'h0;
            key_q   <= '0;
            rcon_q  <= 8'h00;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            rcon_q  <= rcon_d;
        end
    end

    assign cipher = blk_q;
    assign busy   = (fsm_q != IDLE);
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: known-answer and random blocks against a FIPS-197
// reference model, with a scoreboard queue drained by an output monitor.
module tb_aes_encrypt_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, out_ready, sel;
    logic [127:0] pt;
    logic [255:0] kb;
    logic         iv_a, iv_b, ir_a, ir_b, ov_a, ov_b, bsy_a, bsy_b;
    logic [127:0] ct_a, ct_b;
    logic         ir, ov, bsy;
    logic [127:0] ct;

    assign iv_a = in_valid && !sel;
    assign iv_b = in_valid && sel;
    assign ir   = sel ? ir_b : ir_a;
    assign ov   = sel ? ov_b : ov_a;
    assign bsy  = sel ? bsy_b : bsy_a;
    assign ct   = sel ? ct_b : ct_a;

    aes_encrypt_iter #(.KEY_BITS(128)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a),
        .plain_text(pt), .key(kb[255:128]), .out_valid(ov_a),
        .out_ready(out_ready), .cipher(ct_a), .busy(bsy_a)
    );

    aes_encrypt_iter #(.KEY_BITS(256)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b),
        .plain_text(pt), .key(kb), .out_valid(ov_b),
        .out_ready(out_ready), .cipher(ct_b), .busy(bsy_b)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input int act, input int lim);
        n_chk++;
        n_fail++;
        $display("FAIL %s: waited %0d cycles, limit %0d", nm, act, lim);
    endtask

    // Reference model: straight FIPS-197 pseudocode over byte arrays.
    logic [7:0] sbt[256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, cst;
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
                     ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
            sbt[x] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] p,
                                             input logic [255:0] k, input int nk);
        int nr;
        logic [31:0] w[60];
        logic [7:0] s[16], t[16], col[4], cf[4], acc, rc;
        logic [31:0] tmp;
        logic [127:0] res;
        nr = nk + 6;
        cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbt[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
            if (rd != nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) col[r] = s[r+4*c];
                    for (int r = 0; r < 4; r++) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc = acc ^ gmul(cf[(j-r+4)%4], col[j]);
                        s[r+4*c] = acc;
                    end
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    typedef struct {
        logic [127:0] ct;
        int acc;
        int nr;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    bit   have = 0;
    bit   idle_chk = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have = 0;
                idle_chk = 0;
            end else begin
                if (idle_chk) begin
                    chk("in_ready_after_out", 128'(ir), 128'd1);
                    chk("out_valid_after_out", 128'(ov), 128'd0);
                    idle_chk = 0;
                end
                if (ov) begin
                    if (!have) begin
                        if (sbq.size() == 0) begin
                            chk("spurious_out_valid", 128'(ov), 128'd0);
                        end else begin
                            cur = sbq.pop_front();
                            have = 1;
                            chk("cipher", ct, cur.ct);
                            chk("latency", 128'(cyc - cur.acc), 128'(cur.nr));
                        end
                    end else begin
                        chk("cipher_hold", ct, cur.ct);
                        chk("in_ready_in_done", 128'(ir), 128'd0);
                    end
                    if (have && out_ready) begin
                        have = 0;
                        idle_chk = 1;
                    end
                end
            end
        end
    end

    bit rnd_rdy = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            tick();
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input logic [127:0] p, input logic [255:0] k,
                        input bit perturb, input bit has_kat, input logic [127:0] kat);
        int n;
        exp_t e;
        n = 0;
        while (!ir && n < 200) begin
            tick();
            n++;
        end
        if (!ir) begin
            fail("accept_timeout", n, 200);
            return;
        end
        in_valid = 1'b1;
        pt = p;
        kb = k;
        tick();
        e.ct  = has_kat ? kat : aes_ref(p, k, sel ? 8 : 4);
        e.acc = cyc;
        e.nr  = sel ? 14 : 10;
        sbq.push_back(e);
        chk("busy_after_accept", 128'(bsy), 128'd1);
        chk("in_ready_while_busy", 128'(ir), 128'd0);
        if (perturb) begin
            for (int i = 0; i < 8; i++) begin
                pt = r128();
                kb = {r128(), r128()};
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || have || !ir) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) fail("drain_timeout", n, 400);
    endtask

    localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] K3  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sel = 1'b0;
        pt = '0;
        kb = '0;
        build_sbox();
        repeat (3) tick();
        chk("rst_in_ready_128", 128'(ir_a), 128'd0);
        chk("rst_in_ready_256", 128'(ir_b), 128'd0);
        chk("rst_out_valid", 128'(ov_a), 128'd0);
        chk("rst_busy", 128'(bsy_a), 128'd0);
        chk("rst_cipher", ct_a, 128'd0);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_rst", 128'(ir_a), 128'd1);

        send(PT1, {K1, 128'h0}, 0, 1, C1);
        drain();
        send(PT2, {K2, 128'h0}, 0, 1, C2);
        drain();
        send(PT1, {K1, 128'h0}, 1, 1, C1);
        drain();

        out_ready = 1'b0;
        send(PT2, {K2, 128'h0}, 0, 1, C2);
        n = 0;
        while (!ov && n < 50) begin
            tick();
            n++;
        end
        if (!ov) fail("out_valid_timeout", n, 50);
        repeat (20) tick();
        out_ready = 1'b1;
        drain();

        rnd_rdy = 1;
        for (int i = 0; i < 6; i++) send(r128(), {r128(), r128()}, 0, 0, 128'h0);
        drain();
        rnd_rdy = 0;
        tick();
        out_ready = 1'b1;

        send(PT1, {K1, 128'h0}, 0, 1, C1);
        repeat (4) tick();
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("abort_out_valid", 128'(ov_a), 128'd0);
        chk("abort_busy", 128'(bsy_a), 128'd0);
        chk("abort_cipher", ct_a, 128'd0);
        chk("abort_in_ready", 128'(ir_a), 128'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("abort_idle_ready", 128'(ir_a), 128'd1);
        send(PT2, {K2, 128'h0}, 0, 1, C2);
        drain();

        tick();
        sel = 1'b1;
        tick();
        send(PT2, K3, 0, 1, C3);
        drain();
        rnd_rdy = 1;
        for (int i = 0; i < 4; i++) send(r128(), {r128(), r128()}, 0, 0, 128'h0);
        drain();
        rnd_rdy = 0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
